bram_port_arbiter: RTL and testbench

- Shares one single-port read-first BRAM (HIGH_PERFORMANCE or LOW_LATENCY output) between a write requester (e.g. pixel ingest) and a read requester (e.g. processing/display fetch).
- Arbitrates round-robin, one RAM access per cycle.
- Tracks the RAM read latency and returns tagged read responses.
- Provides a clear sweep that writes CLEAR_VALUE to every address.

---
 rtl/bram_port_arbiter.sv | 191 +++++++++++++++++++
 tb/tb_bram_port_arbiter.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bram_port_arbiter.sv
// bram_port_arbiter
//   Shares one single-port, read-first BRAM between a write requester and a
//   read requester. Arbitration is round-robin with one RAM access per cycle.
//   Read responses are tagged with their address and come back after the
//   RAM read latency. A clear sweep writes CLEAR_VALUE to every address.
//
// Ports
//   clka, rsta                       clock, synchronous active-high reset
//   wr_valid/wr_ready/wr_addr/wr_data  write request channel
//   rd_valid/rd_ready/rd_addr        read request channel
//   rd_resp_valid/addr/data          read response strobe (no backpressure)
//   clear_start/clear_busy/clear_done  clear sweep control and status
//   ram_*                            connection to the BRAM port A
module bram_port_arbiter #(
  parameter int                   RAM_WIDTH    = 18,
  parameter int                   RAM_DEPTH    = 1024,
  parameter int                   ADDR_WIDTH   = 10,
  parameter int                   READ_LATENCY = 2,
  parameter logic [RAM_WIDTH-1:0] CLEAR_VALUE  = '0
) (
  input  logic                  clka,
  input  logic                  rsta,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [RAM_WIDTH-1:0]  wr_data,
  input  logic                  rd_valid,
  output logic                  rd_ready,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  rd_resp_valid,
  output logic [ADDR_WIDTH-1:0] rd_resp_addr,
  output logic [RAM_WIDTH-1:0]  rd_resp_data,
  input  logic                  clear_start,
  output logic                  clear_busy,
  output logic                  clear_done,
  output logic [ADDR_WIDTH-1:0] ram_addra,
  output logic [RAM_WIDTH-1:0]  ram_dina,
  output logic                  ram_wea,
  output logic                  ram_ena,
  output logic                  ram_regcea,
  output logic                  ram_rsta,
  input  logic [RAM_WIDTH-1:0]  ram_douta
);

  typedef enum logic {IDLE, CLEAR} state_e;
  typedef enum logic {GRANT_WR, GRANT_RD} grant_e;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(RAM_DEPTH - 1);

  state_e                  state_q, state_d;
  grant_e                  last_grant_q, last_grant_d;
  logic [ADDR_WIDTH-1:0]   sweep_q, sweep_d;
  logic                    clear_done_q, clear_done_d;
  logic                    ram_ena_q, ram_ena_d;
  logic                    ram_wea_q, ram_wea_d;
  logic [ADDR_WIDTH-1:0]   ram_addra_q, ram_addra_d;
  logic [RAM_WIDTH-1:0]    ram_dina_q, ram_dina_d;
  logic [READ_LATENCY-1:0] resp_vld_q;
  logic [ADDR_WIDTH-1:0]   resp_addr_q [READ_LATENCY];

  logic accepting;
  logic wr_acc;
  logic rd_acc;
  logic rd_issue;

  // A read is in the RAM this cycle when the port is enabled without write.
  assign rd_issue = ram_ena_q & ~ram_wea_q;

  // ---------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // the pre-edge value of its sources regardless of statement order.
  always_ff @(posedge clka) begin
    if (rsta) begin
      state_q      <= IDLE;
      last_grant_q <= GRANT_WR;
      sweep_q      <= '0;
      clear_done_q <= 1'b0;
      ram_ena_q    <= 1'b0;
      ram_wea_q    <= 1'b0;
      ram_addra_q  <= '0;
      ram_dina_q   <= '0;
      resp_vld_q   <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      sweep_q      <= sweep_d;
      clear_done_q <= clear_done_d;
      ram_ena_q    <= ram_ena_d;
      ram_wea_q    <= ram_wea_d;
      ram_addra_q  <= ram_addra_d;
      ram_dina_q   <= ram_dina_d;
      resp_vld_q[0] <= rd_issue;
      for (int i = 1; i < READ_LATENCY; i++) resp_vld_q[i] <= resp_vld_q[i-1];
    end
  end

  // NOTE: the address delay line has no reset; only the valid bits that
  // qualify it need a known value, so the wide storage stays reset-free.
  always_ff @(posedge clka) begin
    resp_addr_q[0] <= ram_addra_q;
    for (int i = 1; i < READ_LATENCY; i++) resp_addr_q[i] <= resp_addr_q[i-1];
  end

  // ---------------------------------------------------------------------
  // Next-state logic: sweep sequencing
  // ---------------------------------------------------------------------
  // NOTE: every signal assigned in an always_comb gets a default first, so
  // no path can leave it unassigned and infer a latch.
  always_comb begin
    state_d      = state_q;
    sweep_d      = sweep_q;
    clear_done_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (clear_start) begin
          state_d = CLEAR;
          sweep_d = '0;
        end
      end
      CLEAR: begin
        // The counter holds the address being written this cycle; the
        // sweep ends after the last address instead of wrapping.
        if (sweep_q == LAST_ADDR) begin
          state_d      = IDLE;
          sweep_d      = '0;
          clear_done_d = 1'b1;
        end else begin
          sweep_d = sweep_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // Output logic: arbitration and RAM issue
  // ---------------------------------------------------------------------
  always_comb begin
    // clear_start takes the cycle, so no request is accepted alongside it.
    accepting = (state_q == IDLE) & ~clear_start;
    // A requester is refused only when the other one is also valid and it
    // was the one granted last.
    wr_ready  = accepting & (~rd_valid | (last_grant_q == GRANT_RD));
    rd_ready  = accepting & (~wr_valid | (last_grant_q == GRANT_WR));
    wr_acc    = wr_valid & wr_ready;
    rd_acc    = rd_valid & rd_ready;

    last_grant_d = last_grant_q;
    if (wr_acc)      last_grant_d = GRANT_WR;
    else if (rd_acc) last_grant_d = GRANT_RD;

    ram_ena_d   = 1'b0;
    ram_wea_d   = 1'b0;
    ram_addra_d = ram_addra_q;
    ram_dina_d  = ram_dina_q;
    if ((state_q == IDLE) && clear_start) begin
      ram_ena_d   = 1'b1;
      ram_wea_d   = 1'b1;
      ram_addra_d = '0;
      ram_dina_d  = CLEAR_VALUE;
    end else if ((state_q == CLEAR) && (sweep_q != LAST_ADDR)) begin
      ram_ena_d   = 1'b1;
      ram_wea_d   = 1'b1;
      ram_addra_d = sweep_q + 1'b1;
      ram_dina_d  = CLEAR_VALUE;
    end else if (wr_acc) begin
      ram_ena_d   = 1'b1;
      ram_wea_d   = 1'b1;
      ram_addra_d = wr_addr;
      ram_dina_d  = wr_data;
    end else if (rd_acc) begin
      ram_ena_d   = 1'b1;
      ram_addra_d = rd_addr;
    end
  end

  assign clear_busy    = (state_q == CLEAR);
  assign clear_done    = clear_done_q;
  assign ram_ena       = ram_ena_q;
  assign ram_wea       = ram_wea_q;
  assign ram_addra     = ram_addra_q;
  assign ram_dina      = ram_dina_q;
  assign ram_regcea    = 1'b1;
  assign ram_rsta      = rsta;
  assign rd_resp_valid = resp_vld_q[READ_LATENCY-1];
  assign rd_resp_addr  = resp_addr_q[READ_LATENCY-1];
  assign rd_resp_data  = ram_douta;

endmodule

// File: tb/tb_bram_port_arbiter.sv
// tb_bram_port_arbiter
//   Drives two arbiters (READ_LATENCY 1 and 2) with identical stimulus, each
//   attached to its own behavioural BRAM. A cycle-level reference model
//   predicts ready, RAM issue and clear status; read responses are queued at
//   accept time and popped by per-lane monitors when the DUT strobes.
module tb_bram_port_arbiter;

  localparam int W = 18;
  localparam int D = 16;
  localparam int A = 5;
  localparam logic [W-1:0] CV = '0;

  typedef struct packed {
    logic         ena;
    logic         wea;
    logic [A-1:0] addr;
    logic [W-1:0] dina;
  } iss_t;

  typedef struct packed {
    int           acc;
    logic [A-1:0] addr;
    logic [W-1:0] data;
  } resp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst = 1'b1;
  logic         wv = 1'b0, rv = 1'b0, cs = 1'b0;
  logic [A-1:0] wa = '0, ra = '0;
  logic [W-1:0] wd = '0;

  logic         wr_ready1, rd_ready1, resp_v1, busy1, done1, ena1, wea1, regce1, rrst1;
  logic [A-1:0] resp_a1, addra1;
  logic [W-1:0] resp_d1, dina1, douta1;
  logic         wr_ready2, rd_ready2, resp_v2, busy2, done2, ena2, wea2, regce2, rrst2;
  logic [A-1:0] resp_a2, addra2;
  logic [W-1:0] resp_d2, dina2, douta2;

  bram_port_arbiter #(.RAM_WIDTH(W), .RAM_DEPTH(D), .ADDR_WIDTH(A),
                      .READ_LATENCY(1), .CLEAR_VALUE(CV)) u_dut_l1 (
    .clka(clk), .rsta(rst),
    .wr_valid(wv), .wr_ready(wr_ready1), .wr_addr(wa), .wr_data(wd),
    .rd_valid(rv), .rd_ready(rd_ready1), .rd_addr(ra),
    .rd_resp_valid(resp_v1), .rd_resp_addr(resp_a1), .rd_resp_data(resp_d1),
    .clear_start(cs), .clear_busy(busy1), .clear_done(done1),
    .ram_addra(addra1), .ram_dina(dina1), .ram_wea(wea1), .ram_ena(ena1),
    .ram_regcea(regce1), .ram_rsta(rrst1), .ram_douta(douta1));

  bram_port_arbiter #(.RAM_WIDTH(W), .RAM_DEPTH(D), .ADDR_WIDTH(A),
                      .READ_LATENCY(2), .CLEAR_VALUE(CV)) u_dut_l2 (
    .clka(clk), .rsta(rst),
    .wr_valid(wv), .wr_ready(wr_ready2), .wr_addr(wa), .wr_data(wd),
    .rd_valid(rv), .rd_ready(rd_ready2), .rd_addr(ra),
    .rd_resp_valid(resp_v2), .rd_resp_addr(resp_a2), .rd_resp_data(resp_d2),
    .clear_start(cs), .clear_busy(busy2), .clear_done(done2),
    .ram_addra(addra2), .ram_dina(dina2), .ram_wea(wea2), .ram_ena(ena2),
    .ram_regcea(regce2), .ram_rsta(rrst2), .ram_douta(douta2));

  // Behavioural read-first BRAMs: latch only (LOW_LATENCY) and latch plus
  // output register (HIGH_PERFORMANCE).
  logic [W-1:0] mem1 [2**A];
  logic [W-1:0] mem2 [2**A];
  logic [W-1:0] lat1 = '0, lat2 = '0, oreg2 = '0;
  logic [W-1:0] ref_mem [2**A];

  always @(posedge clk) begin
    if (rrst1) lat1 <= '0;
    else if (ena1) lat1 <= mem1[addra1];
    if (ena1 && wea1) mem1[addra1] <= dina1;
  end
  assign douta1 = lat1;

  always @(posedge clk) begin
    if (rrst2) begin
      lat2  <= '0;
      oreg2 <= '0;
    end else begin
      if (ena2) lat2 <= mem2[addra2];
      if (regce2) oreg2 <= lat2;
    end
    if (ena2 && wea2) mem2[addra2] <= dina2;
  end
  assign douta2 = oreg2;

  // ---------------------------------------------------------------------
  // Scoreboard state
  // ---------------------------------------------------------------------
  int    n_checks = 0;
  int    n_fail   = 0;
  int    cyc      = 0;
  bit    mon_en   = 1'b0;
  resp_t exp_q1[$];
  resp_t exp_q2[$];

  // Reference model: remaining sweep cycles, clear_done due, who was
  // granted last, and the RAM access expected this cycle.
  int   busy_rem = 0;
  bit   done_exp = 1'b0;
  bit   last_rd  = 1'b0;
  iss_t cur_iss  = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic mon(input int lat, input logic v, input logic [A-1:0] a, input logic [W-1:0] d);
    resp_t e;
    bit    have;
    int    due;
    e    = '0;
    have = (lat == 1) ? (exp_q1.size() > 0) : (exp_q2.size() > 0);
    if (have) e = (lat == 1) ? exp_q1[0] : exp_q2[0];
    due = e.acc + 1 + lat;
    if (v === 1'b1) begin
      if (!have) begin
        check($sformatf("l%0d_resp_unexpected", lat), 1, 0);
      end else begin
        if (lat == 1) void'(exp_q1.pop_front());
        else          void'(exp_q2.pop_front());
        check($sformatf("l%0d_resp_cycle", lat), 64'(cyc), 64'(due));
        check($sformatf("l%0d_resp_addr", lat), 64'(a), 64'(e.addr));
        check($sformatf("l%0d_resp_data", lat), 64'(d), 64'(e.data));
      end
    end else if (have && cyc >= due) begin
      check($sformatf("l%0d_resp_missing", lat), 64'(v), 1);
      if (lat == 1) void'(exp_q1.pop_front());
      else          void'(exp_q2.pop_front());
    end
  endtask

  always @(negedge clk) if (mon_en) mon(1, resp_v1, resp_a1, resp_d1);
  always @(negedge clk) if (mon_en) mon(2, resp_v2, resp_a2, resp_d2);

  // Reset in cycle n drops every response that would arrive after n.
  task automatic purge(input int n);
    while (exp_q1.size() > 0 && exp_q1[$].acc + 2 > n) void'(exp_q1.pop_back());
    while (exp_q2.size() > 0 && exp_q2[$].acc + 3 > n) void'(exp_q2.pop_back());
  endtask

  task automatic check_iss(input string ln, input logic ena, input logic wea,
                           input logic [A-1:0] addr, input logic [W-1:0] dina);
    check({ln, "_ram_ena"}, 64'(ena), 64'(cur_iss.ena));
    if (cur_iss.ena) begin
      check({ln, "_ram_wea"}, 64'(wea), 64'(cur_iss.wea));
      check({ln, "_ram_addra"}, 64'(addr), 64'(cur_iss.addr));
      if (cur_iss.wea) check({ln, "_ram_dina"}, 64'(dina), 64'(cur_iss.dina));
    end
  endtask

  // One clock cycle: drive inputs, check this cycle against the model,
  // then advance the model to the next cycle.
  task automatic step(input logic i_wv, input logic [A-1:0] i_wa, input logic [W-1:0] i_wd,
                      input logic i_rv, input logic [A-1:0] i_ra, input logic i_cs,
                      input logic i_rst);
    bit    idle, acc_w, acc_r, cs_go, done_nxt;
    iss_t  nxt;
    resp_t r;
    int    n;
    wv = i_wv; wa = i_wa; wd = i_wd; rv = i_rv; ra = i_ra; cs = i_cs; rst = i_rst;
    @(negedge clk);
    n    = cyc;
    idle = (busy_rem == 0);
    check("l1_clear_busy", 64'(busy1), 64'(!idle));
    check("l2_clear_busy", 64'(busy2), 64'(!idle));
    check("l1_clear_done", 64'(done1), 64'(done_exp));
    check("l2_clear_done", 64'(done2), 64'(done_exp));
    check_iss("l1", ena1, wea1, addra1, dina1);
    check_iss("l2", ena2, wea2, addra2, dina2);

    acc_w = 1'b0; acc_r = 1'b0; cs_go = 1'b0;
    if (!i_rst) begin
      if (!idle) begin
        check("l1_wr_ready_busy", 64'(wr_ready1), 0);
        check("l1_rd_ready_busy", 64'(rd_ready1), 0);
        check("l2_wr_ready_busy", 64'(wr_ready2), 0);
        check("l2_rd_ready_busy", 64'(rd_ready2), 0);
      end else if (i_cs) begin
        cs_go = 1'b1;
        if (i_wv) check("wr_ready_at_clear", 64'(wr_ready1 | wr_ready2), 0);
        if (i_rv) check("rd_ready_at_clear", 64'(rd_ready1 | rd_ready2), 0);
      end else begin
        if (i_wv && i_rv) begin
          acc_r = !last_rd;
          acc_w = last_rd;
        end else begin
          acc_w = i_wv;
          acc_r = i_rv;
        end
        if (i_wv) begin
          check("l1_wr_ready", 64'(wr_ready1), 64'(acc_w));
          check("l2_wr_ready", 64'(wr_ready2), 64'(acc_w));
        end
        if (i_rv) begin
          check("l1_rd_ready", 64'(rd_ready1), 64'(acc_r));
          check("l2_rd_ready", 64'(rd_ready2), 64'(acc_r));
        end
      end
    end

    nxt      = '0;
    done_nxt = 1'b0;
    if (i_rst) begin
      busy_rem = 0;
      last_rd  = 1'b0;
    end else if (cs_go) begin
      busy_rem = D;
      nxt.ena = 1'b1; nxt.wea = 1'b1; nxt.addr = '0; nxt.dina = CV;
    end else if (!idle) begin
      busy_rem--;
      if (busy_rem > 0) begin
        nxt.ena = 1'b1; nxt.wea = 1'b1; nxt.addr = A'(D - busy_rem); nxt.dina = CV;
      end else begin
        done_nxt = 1'b1;
      end
    end else if (acc_w) begin
      last_rd = 1'b0;
      nxt.ena = 1'b1; nxt.wea = 1'b1; nxt.addr = i_wa; nxt.dina = i_wd;
    end else if (acc_r) begin
      last_rd = 1'b1;
      nxt.ena = 1'b1; nxt.wea = 1'b0; nxt.addr = i_ra;
      r.acc = n; r.addr = i_ra; r.data = ref_mem[i_ra];
      exp_q1.push_back(r);
      exp_q2.push_back(r);
    end
    if (nxt.ena && nxt.wea) ref_mem[nxt.addr] = nxt.dina;

    @(posedge clk);
    #1;
    if (i_rst) purge(n);
    cur_iss  = nxt;
    done_exp = done_nxt;
  endtask

  task automatic idle_steps(input int k);
    for (int i = 0; i < k; i++) step(1'b0, '0, '0, 1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic rnd_step(input int cs_pct);
    logic         v_w, v_r, c;
    logic [A-1:0] aw, ar;
    logic [W-1:0] dw;
    v_w = ($urandom_range(99) < 60);
    v_r = ($urandom_range(99) < 60);
    c   = ($urandom_range(99) < cs_pct);
    aw  = A'($urandom_range(D - 1));
    ar  = A'($urandom_range(D - 1));
    dw  = W'($urandom);
    step(v_w, aw, dw, v_r, ar, c, 1'b0);
  endtask

  initial begin
    for (int i = 0; i < 2**A; i++) begin
      mem1[i]    = W'(i * 37 + 5);
      mem2[i]    = W'(i * 37 + 5);
      ref_mem[i] = W'(i * 37 + 5);
    end

    // Power-on reset for two edges, then check the reset state.
    @(posedge clk);
    @(negedge clk);
    check("l1_ram_rsta_high", 64'(rrst1), 1);
    check("l2_ram_rsta_high", 64'(rrst2), 1);
    @(posedge clk);
    #1;
    rst    = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);
    check("rst_clear_busy", 64'({busy1, busy2}), 0);
    check("rst_clear_done", 64'({done1, done2}), 0);
    check("rst_resp_valid", 64'({resp_v1, resp_v2}), 0);
    check("rst_ram_ena_wea", 64'({ena1, wea1, ena2, wea2}), 0);
    check("rst_ram_addra", 64'({addra1, addra2}), 0);
    check("rst_ram_dina", 64'({dina1, dina2}), 0);
    check("ram_regcea", 64'({regce1, regce2}), 64'b11);
    check("ram_rsta_low", 64'({rrst1, rrst2}), 0);
    @(posedge clk);
    #1;

    // Lone write then a read of the same address.
    step(1'b1, A'(5), W'(18'h1234), 1'b0, '0, 1'b0, 1'b0);
    idle_steps(2);
    step(1'b0, '0, '0, 1'b1, A'(5), 1'b0, 1'b0);
    idle_steps(4);

    // Both requesters held for six cycles straight out of reset.
    step(1'b0, '0, '0, 1'b0, '0, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++)
      step(1'b1, A'(i), W'($urandom), 1'b1, A'(i + 8), 1'b0, 1'b0);
    idle_steps(4);

    // Write followed immediately by a read of the same address.
    step(1'b1, A'(7), W'(3), 1'b0, '0, 1'b0, 1'b0);
    step(1'b0, '0, '0, 1'b1, A'(7), 1'b0, 1'b0);
    idle_steps(4);

    // Full clear sweep with both requesters valid; read back afterwards.
    step(1'b1, A'(2), W'(9), 1'b1, A'(3), 1'b1, 1'b0);
    for (int i = 0; i < D; i++) rnd_step(20);
    step(1'b0, '0, '0, 1'b1, A'(5), 1'b0, 1'b0);
    idle_steps(4);

    // Reset with a read in flight: its response must never appear.
    step(1'b0, '0, '0, 1'b1, A'(3), 1'b0, 1'b0);
    step(1'b0, '0, '0, 1'b0, '0, 1'b0, 1'b1);
    idle_steps(4);

    // Reset while the sweep writes address 8, then a fresh sweep.
    step(1'b0, '0, '0, 1'b0, '0, 1'b1, 1'b0);
    idle_steps(8);
    step(1'b0, '0, '0, 1'b0, '0, 1'b0, 1'b1);
    idle_steps(2);
    step(1'b0, '0, '0, 1'b0, '0, 1'b1, 1'b0);
    idle_steps(D + 2);

    // Random traffic with occasional clears and resets.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(199) == 0) step(1'b0, '0, '0, 1'b0, '0, 1'b0, 1'b1);
      else rnd_step(2);
    end

    // Drain outstanding responses within a bounded number of cycles.
    for (int i = 0; i < 40 && (busy_rem > 0 || exp_q1.size() > 0 || exp_q2.size() > 0); i++)
      idle_steps(1);
    check("l1_drain_empty", 64'(exp_q1.size()), 0);
    check("l2_drain_empty", 64'(exp_q2.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
